// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op and state encodings,
// iteration mode, and the iteration counter width helper.
package hilo_muldiv_unit_pkg;

   typedef enum logic [2:0] {
      MULDIV_OP_MULT  = 3'd0,
      MULDIV_OP_MULTU = 3'd1,
      MULDIV_OP_DIV   = 3'd2,
      MULDIV_OP_DIVU  = 3'd3,
      MULDIV_OP_MTHI  = 3'd4,
      MULDIV_OP_MTLO  = 3'd5
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FIN
   } muldiv_state_e;

   typedef enum logic {
      ITER_MUL,
      ITER_DIV
   } iter_mode_e;

   function automatic int muldiv_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the execute-stage controller (master) and the
// multiply/divide unit (slave).
interface hilo_muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] src0;
   logic [WIDTH-1:0] src1;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, src0, src1,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, src0, src1,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/hilo_muldiv_unit_iter_core.sv
// One combinational iteration of the unit: a shift-add multiply step or a
// restoring divide step on the 2*WIDTH accumulator.
module muldiv_iter_core
   import hilo_muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   operand,
   input  iter_mode_e         mode,
   output logic [2*WIDTH-1:0] acc_next
);

   logic [WIDTH:0] add_sum;
   logic [WIDTH:0] trial;

   // NOTE: every signal driven here gets a value on every path first, so no latch is inferred.
   always_comb begin
      add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
      trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
      acc_next = acc;
      if (mode == ITER_MUL) begin
         // Multiplier sits in the low half and is consumed LSB first.
         acc_next = {add_sum, acc[WIDTH-1:1]};
      end else if (!trial[WIDTH]) begin
         acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         acc_next = {acc[2*WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Optional feature: define MULDIV_FAST_ZERO_EN to resolve zero operands without iterating.
module hilo_muldiv_unit
   import hilo_muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic               clk,
   input logic               rst_n,
   hilo_muldiv_unit_if.slave bus
);

   localparam int               CNT_W     = muldiv_cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
`ifdef MULDIV_FAST_ZERO_EN
   localparam bit FAST_ZERO = 1'b1;
`else
   localparam bit FAST_ZERO = 1'b0;
`endif

   muldiv_state_e      state;
   iter_mode_e         mode;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               neg_main;
   logic               neg_rem;
   logic               dbz_pend;
   logic               busy_q;
   logic               done_q;
   logic               dbz_q;

   logic               is_signed;
   logic               src0_zero;
   logic               src1_zero;
   logic               skip_mul;
   logic               skip_div;
   logic [WIDTH-1:0]   abs_src0;
   logic [WIDTH-1:0]   abs_src1;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   hi_res;
   logic [WIDTH-1:0]   lo_res;

   muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
      .acc      (acc),
      .operand  (opnd),
      .mode     (mode),
      .acc_next (acc_next)
   );

   // Request decode: magnitudes for the signed ops and zero-operand shortcuts.
   always_comb begin
      is_signed = (bus.op == MULDIV_OP_MULT) || (bus.op == MULDIV_OP_DIV);
      src0_zero = (bus.src0 == {WIDTH{1'b0}});
      src1_zero = (bus.src1 == {WIDTH{1'b0}});
      abs_src0  = (is_signed && bus.src0[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.src0) : bus.src0;
      abs_src1  = (is_signed && bus.src1[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.src1) : bus.src1;
      skip_mul  = FAST_ZERO && (src0_zero || src1_zero);
      skip_div  = FAST_ZERO && src1_zero;
   end

   // Sign fix-up applied to the unsigned iteration result on the way out of FIN.
   always_comb begin
      prod_fix = neg_main ? ({(2*WIDTH){1'b0}} - acc) : acc;
      hi_res   = prod_fix[2*WIDTH-1:WIDTH];
      lo_res   = prod_fix[WIDTH-1:0];
      if (mode == ITER_DIV) begin
         lo_res = neg_main ? ({WIDTH{1'b0}} - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
         hi_res = neg_rem ? ({WIDTH{1'b0}} - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
      end
   end

   // NOTE: all state, including the accumulator, is cleared on reset and updated with non-blocking assignments.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         mode     <= ITER_MUL;
         cnt      <= '0;
         acc      <= '0;
         opnd     <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         neg_main <= 1'b0;
         neg_rem  <= 1'b0;
         dbz_pend <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  case (bus.op)
                     MULDIV_OP_MULT, MULDIV_OP_MULTU: begin
                        mode     <= ITER_MUL;
                        opnd     <= abs_src0;
                        acc      <= skip_mul ? '0 : {{WIDTH{1'b0}}, abs_src1};
                        neg_main <= is_signed && (bus.src0[WIDTH-1] ^ bus.src1[WIDTH-1]);
                        neg_rem  <= 1'b0;
                        dbz_pend <= 1'b0;
                        cnt      <= '0;
                        busy_q   <= 1'b1;
                        state    <= skip_mul ? ST_FIN : ST_RUN;
                     end
                     MULDIV_OP_DIV, MULDIV_OP_DIVU: begin
                        mode     <= ITER_DIV;
                        cnt      <= '0;
                        busy_q   <= 1'b1;
                        dbz_pend <= src1_zero;
                        state    <= skip_div ? ST_FIN : ST_RUN;
                        if (src1_zero) begin
                           // Unsigned divide by zero naturally yields all-ones quotient and the raw dividend.
                           opnd     <= '0;
                           acc      <= skip_div ? {bus.src0, ALL_ONES} : {{WIDTH{1'b0}}, bus.src0};
                           neg_main <= 1'b0;
                           neg_rem  <= 1'b0;
                        end else begin
                           opnd     <= abs_src1;
                           acc      <= {{WIDTH{1'b0}}, abs_src0};
                           neg_main <= is_signed && (bus.src0[WIDTH-1] ^ bus.src1[WIDTH-1]);
                           neg_rem  <= is_signed && bus.src0[WIDTH-1];
                        end
                     end
                     MULDIV_OP_MTHI: hi_q <= bus.src0;
                     MULDIV_OP_MTLO: lo_q <= bus.src0;
                     default: ;
                  endcase
               end
            end
            ST_RUN: begin
               acc <= acc_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST_ITER) begin
                  state <= ST_FIN;
               end
            end
            ST_FIN: begin
               hi_q   <= hi_res;
               lo_q   <= lo_res;
               done_q <= 1'b1;
               dbz_q  <= dbz_pend;
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;

endmodule
